// File: rtl/biquad_coeff_sequencer_pkg.sv
// Shared definitions for the biquad coefficient sequencer.
//   NUM_SLOTS      coefficient words per biquad
//   UPDATE_OFFSET  register offset of the commit (update) strobe
//   UPDATE_WORD    value written to the update register
//   seq_state_e    sequencer FSM state, also exported on the debug port
//   slot_offset()  maps a coefficient slot to its register offset
package biquad_seq_pkg;

    localparam int          NUM_SLOTS     = 25;
    localparam logic [7:0]  UPDATE_OFFSET = 8'h00;
    localparam logic [31:0] UPDATE_WORD   = 32'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_FETCH,
        S_WRITE,
        S_UPDATE,
        S_UPD_WR,
        S_RST,
        S_DONE
    } seq_state_e;

    // Several consecutive slots share one register address; the biquad
    // shifts successive writes into its internal coefficient chain.
    function automatic logic [7:0] slot_offset(input logic [4:0] slot);
        logic [7:0] off;
        if (slot < 5'd2)       off = 8'h04;
        else if (slot < 5'd6)  off = 8'h08;
        else if (slot < 5'd8)  off = 8'h0C;
        else if (slot < 5'd15) off = 8'h10;
        else if (slot < 5'd23) off = 8'h14;
        else if (slot == 5'd23) off = 8'h18;
        else                   off = 8'h1C;
        return off;
    endfunction

endpackage

// File: rtl/biquad_coeff_sequencer_if.sv
// Wishbone write-only master bus between the sequencer and the trigger
// chain slave port.
//   m_wb_cyc_o/stb_o/we_o  master strobes (all equal, write-only master)
//   m_wb_sel_o             byte selects, all ones during a write
//   m_wb_adr_o/dat_o       register address / write data
//   m_wb_ack_i/err_i       slave response
// Handshake: the master raises cyc/stb with stable adr/dat and holds them
// until it samples ack or err high on a rising clock edge; the transfer
// completes on that edge and cyc/stb drop in the following cycle.
interface biquad_coeff_sequencer_if;
    logic        m_wb_cyc_o;
    logic        m_wb_stb_o;
    logic        m_wb_we_o;
    logic [3:0]  m_wb_sel_o;
    logic [7:0]  m_wb_adr_o;
    logic [31:0] m_wb_dat_o;
    logic        m_wb_ack_i;
    logic        m_wb_err_i;

    modport master (
        output m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, m_wb_sel_o, m_wb_adr_o, m_wb_dat_o,
        input  m_wb_ack_i, m_wb_err_i
    );

    modport slave (
        input  m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, m_wb_sel_o, m_wb_adr_o, m_wb_dat_o,
        output m_wb_ack_i, m_wb_err_i
    );
endinterface

// File: rtl/biquad_coeff_sequencer_writer.sv
// wb_single_writer: performs one Wishbone write per request.
//   wb_clk_i, wb_rst_ni  clock, asynchronous active-low reset
//   req_i                one-cycle request; adr_i/dat_i captured with it
//   ok_o                 transfer acknowledged (this cycle)
//   fail_o               slave error or TIMEOUT cycles without ack
//   m_wb                 Wishbone master bus
// Capturing dat_i on req_i doubles as the one-cycle coefficient read.
module wb_single_writer #(
    parameter int TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        req_i,
    input  logic [7:0]  adr_i,
    input  logic [31:0] dat_i,
    output logic        ok_o,
    output logic        fail_o,
    biquad_coeff_sequencer_if.master m_wb
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic          cyc_q;
    logic [7:0]    adr_q;
    logic [31:0]   dat_q;
    logic [TW-1:0] wait_q;
    logic          timed_out;

    // wait_q counts cycles already spent with cyc high; the TIMEOUT-th
    // unacknowledged cycle is the last one.
    assign timed_out = (wait_q == TW'(TIMEOUT - 1));
    assign ok_o      = cyc_q && m_wb.m_wb_ack_i && !m_wb.m_wb_err_i;
    assign fail_o    = cyc_q && (m_wb.m_wb_err_i || (!m_wb.m_wb_ack_i && timed_out));

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cyc_q  <= 1'b0;
            adr_q  <= '0;
            dat_q  <= '0;
            wait_q <= '0;
        end else if (cyc_q) begin
            if (ok_o || fail_o) cyc_q <= 1'b0;
            wait_q <= wait_q + TW'(1);
        end else if (req_i) begin
            cyc_q  <= 1'b1;
            adr_q  <= adr_i;
            dat_q  <= dat_i;
            wait_q <= '0;
        end
    end

    assign m_wb.m_wb_cyc_o = cyc_q;
    assign m_wb.m_wb_stb_o = cyc_q;
    assign m_wb.m_wb_we_o  = cyc_q;
    assign m_wb.m_wb_sel_o = cyc_q ? 4'hF : 4'h0;
    assign m_wb.m_wb_adr_o = cyc_q ? adr_q : 8'h00;
    assign m_wb.m_wb_dat_o = cyc_q ? dat_q : 32'h0;

endmodule

// File: rtl/biquad_coeff_sequencer.sv
// biquad_coeff_sequencer: replays the coefficient write schedule into the
// selected biquads over Wishbone, commits each with an update write, then
// pulses the biquad reset.
//   wb_clk_i, wb_rst_ni     clock, asynchronous active-low reset
//   coef_we_i/addr_i/dat_i  host writes into the coefficient buffer (idle only)
//   start_i, bq_mask_i      start request and biquad selection
//   busy_o, done_o, err_o   status: in progress, completion pulse, sticky error
//   bq_reset_o              biquad reset pulse, active high
//   dbg_state_o             current FSM state
//   m_wb                    Wishbone master bus
module biquad_coeff_sequencer
    import biquad_seq_pkg::*;
#(
    parameter int         NUM_BQ       = 2,
    parameter logic [7:0] BQ_STRIDE    = 8'h80,
    parameter int         TIMEOUT      = 255,
    parameter int         RESET_CYCLES = 32
) (
    input  logic                                   wb_clk_i,
    input  logic                                   wb_rst_ni,
    input  logic                                   coef_we_i,
    input  logic [$clog2(NUM_BQ*NUM_SLOTS)-1:0]    coef_addr_i,
    input  logic [31:0]                            coef_dat_i,
    input  logic                                   start_i,
    input  logic [NUM_BQ-1:0]                      bq_mask_i,
    output logic                                   busy_o,
    output logic                                   done_o,
    output logic                                   err_o,
    output logic                                   bq_reset_o,
    output seq_state_e                             dbg_state_o,
    biquad_coeff_sequencer_if.master               m_wb
);

    localparam int AW    = $clog2(NUM_BQ * NUM_SLOTS);
    localparam int BQW   = (NUM_BQ > 1) ? $clog2(NUM_BQ) : 1;
    localparam int RCW   = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int DEPTH = NUM_BQ * NUM_SLOTS;

    logic [31:0]     coef_buf [DEPTH];

    seq_state_e      state_q, state_d;
    logic [NUM_BQ-1:0] pend_q, pend_d;
    logic [BQW-1:0]  bq_q, bq_d;
    logic [4:0]      slot_q, slot_d;
    logic [RCW-1:0]  rst_cnt_q, rst_cnt_d;
    logic            err_q, err_d;

    logic            wr_req, wr_ok, wr_fail;
    logic [7:0]      wr_adr;
    logic [31:0]     wr_dat;
    logic [7:0]      bq_base;
    logic [AW-1:0]   fetch_idx;
    logic [31:0]     fetch_word;

    assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o      = (state_q == S_DONE);
    assign bq_reset_o  = (state_q == S_RST);
    assign err_o       = err_q;
    assign dbg_state_o = state_q;

    // Host writes are blocked while busy so a sequence never sees a
    // partially updated coefficient set.
    always_ff @(posedge wb_clk_i) begin
        if (coef_we_i && !busy_o && (int'(coef_addr_i) < DEPTH))
            coef_buf[coef_addr_i] <= coef_dat_i;
    end

    assign bq_base    = 8'(int'(bq_q) * int'(BQ_STRIDE));
    assign fetch_idx  = AW'(int'(bq_q) * NUM_SLOTS + int'(slot_q));
    assign fetch_word = coef_buf[fetch_idx];

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= S_IDLE;
            pend_q    <= '0;
            bq_q      <= '0;
            slot_q    <= '0;
            rst_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            bq_q      <= bq_d;
            slot_q    <= slot_d;
            rst_cnt_q <= rst_cnt_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        bq_d      = bq_q;
        slot_d    = slot_q;
        rst_cnt_d = rst_cnt_q;
        err_d     = err_q;
        wr_req    = 1'b0;
        wr_adr    = bq_base + slot_offset(slot_q);
        wr_dat    = fetch_word;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    err_d   = 1'b0;
                    pend_d  = bq_mask_i;
                    state_d = (bq_mask_i != '0) ? S_SEL : S_DONE;
                end
            end
            S_SEL: begin
                // Descending scan so the lowest pending biquad wins.
                state_d = S_DONE;
                for (int i = NUM_BQ - 1; i >= 0; i--) begin
                    if (pend_q[i]) begin
                        bq_d    = BQW'(i);
                        slot_d  = '0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                wr_req  = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (wr_fail) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (wr_ok) begin
                    if (slot_q == 5'(NUM_SLOTS - 1)) begin
                        state_d = S_UPDATE;
                    end else begin
                        slot_d  = slot_q + 5'd1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_UPDATE: begin
                wr_req  = 1'b1;
                wr_adr  = bq_base + UPDATE_OFFSET;
                wr_dat  = UPDATE_WORD;
                state_d = S_UPD_WR;
            end
            S_UPD_WR: begin
                if (wr_fail) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (wr_ok) begin
                    pend_d[bq_q] = 1'b0;
                    // Go straight to the reset pulse after the last commit
                    // so it starts the cycle after that ack.
                    if (pend_d != '0) begin
                        state_d = S_SEL;
                    end else if (RESET_CYCLES > 0) begin
                        rst_cnt_d = RCW'(RESET_CYCLES - 1);
                        state_d   = S_RST;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RST: begin
                if (rst_cnt_q == '0) state_d = S_DONE;
                else                 rst_cnt_d = rst_cnt_q - RCW'(1);
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    wb_single_writer #(
        .TIMEOUT (TIMEOUT)
    ) u_writer (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .req_i     (wr_req),
        .adr_i     (wr_adr),
        .dat_i     (wr_dat),
        .ok_o      (wr_ok),
        .fail_o    (wr_fail),
        .m_wb      (m_wb)
    );

endmodule
